pwm_breath_multi: RTL and testbench

//  Multi-channel LED PWM engine: CH_NUM outputs share one period counter. Modes: static per-channel duty,

---
 rtl/pwm_breath_multi.sv | 174 +++++++++++++++++
 tb/tb_pwm_breath_multi.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_breath_multi.sv
// pwm_breath_multi: CH_NUM PWM outputs on one shared period counter; static, breathing or chase modes.
// Build option PWM_GAMMA_EN: ramp duty uses square-law dimming (level*level)>>DUTY_W; static duty stays linear.
module pwm_breath_multi #(
  parameter int CH_NUM = 3,
  parameter int DUTY_W = 8,
  parameter int PRESC  = 20,
  parameter int STEP_T = 3,
  localparam int CIW   = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
) (
  input  logic                     sys_clk,
  input  logic                     sys_rst,
  input  logic [1:0]               mode,
  input  logic [CH_NUM*DUTY_W-1:0] duty_in,
  input  logic                     load,
  output logic [CH_NUM-1:0]        pwm_out,
  output logic                     period_tick,
  output logic [CIW-1:0]           chase_idx
);

  localparam int DMAX = (1 << DUTY_W) - 1;
  localparam int PW   = (PRESC > 1) ? $clog2(PRESC) : 1;
  localparam int TW   = (STEP_T > 1) ? $clog2(STEP_T) : 1;

  localparam logic [PW-1:0]     PRE_LAST  = PW'(PRESC - 1);
  localparam logic [DUTY_W-1:0] SLOT_LAST = DUTY_W'(DMAX - 1);
  localparam logic [DUTY_W-1:0] LVL_MAX   = DUTY_W'(DMAX);
  localparam logic [TW-1:0]     STEP_LAST = TW'(STEP_T - 1);
  localparam logic [CIW-1:0]    IDX_LAST  = CIW'(CH_NUM - 1);

  typedef enum logic [1:0] {
    MODE_STATIC = 2'd0,
    MODE_BREATH = 2'd1,
    MODE_CHASE  = 2'd2
  } mode_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  function automatic mode_e eff_mode(input logic [1:0] m);
    case (m)
      2'd1:    return MODE_BREATH;
      2'd2:    return MODE_CHASE;
      default: return MODE_STATIC;
    endcase
  endfunction

  function automatic logic [DUTY_W-1:0] shape(input logic [DUTY_W-1:0] lv);
`ifdef PWM_GAMMA_EN
    logic [2*DUTY_W-1:0] sq;
    sq = {{DUTY_W{1'b0}}, lv} * {{DUTY_W{1'b0}}, lv};
    sq = sq >> DUTY_W;
    return sq[DUTY_W-1:0];
`else
    return lv;
`endif
  endfunction

  logic [PW-1:0]                   pre_q, pre_d;
  logic [DUTY_W-1:0]               slot_q, slot_d;
  logic                            pb;

  logic [CH_NUM*DUTY_W-1:0]        duty_sh_q, duty_sh_d;
  logic [1:0]                      mode_sh_q, mode_sh_d;
  logic [CH_NUM-1:0][DUTY_W-1:0]   duty_act_q, duty_act_d;
  mode_e                           mode_act_q, mode_act_d;
  mode_e                           mode_nx;

  logic [DUTY_W-1:0]               level_q, level_d;
  dir_e                            dir_q, dir_d;
  logic [TW-1:0]                   step_q, step_d;
  logic [CIW-1:0]                  idx_q, idx_d;
  logic [CH_NUM-1:0]               pwm_q, pwm_d;

  // Period counter: PRESC clocks per slot, DMAX slots per period.
  always_comb begin
    pre_d  = pre_q + 1'b1;
    slot_d = slot_q;
    if (pre_q == PRE_LAST) begin
      pre_d  = '0;
      slot_d = (slot_q == SLOT_LAST) ? '0 : slot_q + 1'b1;
    end
  end

  assign pb = (pre_q == PRE_LAST) && (slot_q == SLOT_LAST);

  always_comb begin
    duty_sh_d  = load ? duty_in : duty_sh_q;
    mode_sh_d  = load ? mode : mode_sh_q;
    mode_nx    = eff_mode(mode_sh_d);
    mode_act_d = mode_act_q;
    duty_act_d = duty_act_q;
    level_d    = level_q;
    dir_d      = dir_q;
    step_d     = step_q;
    idx_d      = idx_q;

    if (pb) begin
      mode_act_d = mode_nx;
      if (mode_nx != MODE_STATIC) begin
        if (mode_nx != mode_act_q) begin
          level_d = '0;
          dir_d   = DIR_UP;
          step_d  = '0;
          idx_d   = '0;
        end else if (step_q == STEP_LAST) begin
          step_d = '0;
          if (dir_q == DIR_UP) begin
            level_d = level_q + 1'b1;
            if (level_d == LVL_MAX) dir_d = DIR_DOWN;
          end else begin
            level_d = level_q - 1'b1;
            if (level_d == '0) begin
              dir_d = DIR_UP;
              // Chase hands the ramp to the next channel each time it fades out.
              if (mode_nx == MODE_CHASE) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
            end
          end
        end else begin
          step_d = step_q + 1'b1;
        end
      end

      for (int i = 0; i < CH_NUM; i++) begin
        case (mode_nx)
          MODE_BREATH: duty_act_d[i] = shape(level_d);
          MODE_CHASE:  duty_act_d[i] = (idx_d == CIW'(i)) ? shape(level_d) : '0;
          default:     duty_act_d[i] = duty_sh_d[i*DUTY_W +: DUTY_W];
        endcase
      end
    end
  end

  always_comb begin
    pwm_d = '0;
    for (int i = 0; i < CH_NUM; i++) begin
      pwm_d[i] = (slot_q < duty_act_q[i]);
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      pre_q      <= '0;
      slot_q     <= '0;
      duty_sh_q  <= '0;
      mode_sh_q  <= 2'd0;
      duty_act_q <= '0;
      mode_act_q <= MODE_STATIC;
      level_q    <= '0;
      dir_q      <= DIR_UP;
      step_q     <= '0;
      idx_q      <= '0;
      pwm_q      <= '0;
    end else begin
      pre_q      <= pre_d;
      slot_q     <= slot_d;
      duty_sh_q  <= duty_sh_d;
      mode_sh_q  <= mode_sh_d;
      duty_act_q <= duty_act_d;
      mode_act_q <= mode_act_d;
      level_q    <= level_d;
      dir_q      <= dir_d;
      step_q     <= step_d;
      idx_q      <= idx_d;
      pwm_q      <= pwm_d;
    end
  end

  assign pwm_out     = pwm_q;
  assign period_tick = pb;
  assign chase_idx   = idx_q;

endmodule

// File: tb/tb_pwm_breath_multi.sv
// Bench for pwm_breath_multi: period-level reference model checked every cycle, plus directed literal checks.
module tb_pwm_breath_multi;

  localparam int CH   = 3;
  localparam int DW   = 4;
  localparam int PRE  = 2;
  localparam int STP  = 1;
  localparam int DMX  = 15;
  localparam int PER  = PRE * DMX;

  logic          sys_clk = 1'b0;
  logic          sys_rst = 1'b1;
  logic [1:0]    mode    = 2'd0;
  logic [CH*DW-1:0] duty_in = '0;
  logic          load    = 1'b0;
  logic [CH-1:0] pwm_out;
  logic          period_tick;
  logic [1:0]    chase_idx;

  int total = 0;
  int bad   = 0;

  pwm_breath_multi #(.CH_NUM(CH), .DUTY_W(DW), .PRESC(PRE), .STEP_T(STP)) dut (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .mode       (mode),
    .duty_in    (duty_in),
    .load       (load),
    .pwm_out    (pwm_out),
    .period_tick(period_tick),
    .chase_idx  (chase_idx)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int f_lvl(input int l);
`ifdef PWM_GAMMA_EN
    return (l * l) >> DW;
`else
    return l;
`endif
  endfunction

  function automatic int tri_lvl(input int j);
    return (j <= DMX) ? j : 2 * DMX - j;
  endfunction

  function automatic int eff(input logic [1:0] m);
    return (m == 2'd1 || m == 2'd2) ? int'(m) : 0;
  endfunction

  // Reference model: per-period duties derived from periods elapsed since the ramp mode was entered.
  bit         m_valid = 1'b0;
  int         pos, cur, sh_mode, k, e_idx;
  int         act [CH];
  int         sh_duty [CH];
  logic [CH-1:0] e_pwm, nxt_pwm;

  always @(posedge sys_clk) begin
    if (sys_rst) begin
      m_valid = 1'b1;
      pos = 0; cur = 0; sh_mode = 0; k = 0; e_idx = 0; e_pwm = '0;
      for (int c = 0; c < CH; c++) begin act[c] = 0; sh_duty[c] = 0; end
    end else begin
      for (int c = 0; c < CH; c++) nxt_pwm[c] = ((pos / PRE) < act[c]);
      if (load) begin
        sh_mode = eff(mode);
        for (int c = 0; c < CH; c++) sh_duty[c] = int'(duty_in[c*DW +: DW]);
      end
      if (pos == PER - 1) begin
        int li, lv;
        if (sh_mode != 0 && sh_mode != cur) k = 0;
        else if (sh_mode != 0) k++;
        cur = sh_mode;
        li = k / STP;
        lv = f_lvl(tri_lvl(li % (2 * DMX)));
        if (cur == 2) e_idx = (li / (2 * DMX)) % CH;
        else if (cur == 1) e_idx = 0;
        for (int c = 0; c < CH; c++) begin
          if (cur == 0) act[c] = sh_duty[c];
          else if (cur == 1) act[c] = lv;
          else act[c] = (c == e_idx) ? lv : 0;
        end
      end
      pos = (pos + 1) % PER;
      e_pwm = nxt_pwm;
    end
  end

  initial begin
    forever begin
      @(negedge sys_clk);
      if (m_valid) begin
        chk("pwm_out", int'(pwm_out), int'(e_pwm));
        chk("period_tick", int'(period_tick), (pos == PER - 1) ? 1 : 0);
        chk("chase_idx", int'(chase_idx), e_idx);
      end
    end
  end

  int hi [0:90][0:2];
  int ridx [0:90];

  task automatic wait_tick(input string tag);
    int n = 0;
    @(negedge sys_clk);
    while (!period_tick && n < 100) begin
      @(negedge sys_clk);
      n++;
    end
    if (!period_tick) begin
      total++;
      bad++;
      $display("FAIL %s: no period_tick within 100 clocks", tag);
    end
  endtask

  // Called at a period_tick negedge; records high clocks per channel for n consecutive output periods.
  task automatic measure(input int n);
    @(negedge sys_clk);
    load = 1'b0;
    for (int p = 0; p < n; p++) begin
      for (int c = 0; c < CH; c++) hi[p][c] = 0;
      for (int t = 0; t < PER; t++) begin
        @(negedge sys_clk);
        for (int c = 0; c < CH; c++) hi[p][c] += int'(pwm_out[c]);
        if (t == 0) ridx[p] = int'(chase_idx);
      end
    end
  endtask

  task automatic do_load(input logic [1:0] m, input int d2, input int d1, input int d0);
    mode    = m;
    duty_in = {DW'(d2), DW'(d1), DW'(d0)};
    load    = 1'b1;
    @(negedge sys_clk);
    load    = 1'b0;
  endtask

  initial begin
    int cnt, ex;
    // 1: reset, idle outputs, tick spacing
    repeat (3) @(negedge sys_clk);
    sys_rst = 1'b0;
    wait_tick("t1_first");
    cnt = 0;
    do begin
      @(negedge sys_clk);
      cnt++;
    end while (!period_tick && cnt < 100);
    chk("t1_tick_spacing", cnt, 30);
    measure(1);
    chk("t1_idle_ch0", hi[0][0], 0);
    chk("t1_idle_ch1", hi[0][1], 0);
    chk("t1_idle_ch2", hi[0][2], 0);

    // 2: static duties {15,7,0}
    repeat (7) @(negedge sys_clk);
    do_load(2'd0, 15, 7, 0);
    wait_tick("t2");
    measure(1);
    chk("t2_ch0", hi[0][0], 0);
    chk("t2_ch1", hi[0][1], 14);
    chk("t2_ch2", hi[0][2], 30);

    // 3: two loads in one period, last wins; load on the boundary cycle
    wait_tick("t3a");
    repeat (5) @(negedge sys_clk);
    do_load(2'd0, 15, 7, 3);
    repeat (3) @(negedge sys_clk);
    do_load(2'd0, 15, 7, 9);
    wait_tick("t3b");
    measure(1);
    chk("t3_ch0_last_wins", hi[0][0], 18);
    chk("t3_ch1", hi[0][1], 14);
    wait_tick("t3c");
    mode    = 2'd0;
    duty_in = {4'd15, 4'd7, 4'd5};
    load    = 1'b1;
    measure(1);
    chk("t3_load_on_pb", hi[0][0], 10);

    // 4: breathing, all channels equal
    repeat (4) @(negedge sys_clk);
    do_load(2'd1, 15, 7, 5);
    wait_tick("t4");
    measure(31);
    for (int p = 0; p < 31; p++) begin
      ex = 2 * f_lvl(tri_lvl(p % 30));
      for (int c = 0; c < CH; c++) chk($sformatf("t4_breath_p%0d_ch%0d", p, c), hi[p][c], ex);
    end
`ifdef PWM_GAMMA_EN
    chk("t4_peak", hi[15][0], 28);
    chk("t4_lvl4", hi[4][0], 2);
`else
    chk("t4_peak", hi[15][0], 30);
    chk("t4_lvl4", hi[4][0], 8);
`endif

    // 5: chase rotation
    repeat (9) @(negedge sys_clk);
    do_load(2'd2, 15, 7, 5);
    wait_tick("t5");
    measure(91);
    for (int p = 0; p < 91; p++) begin
      ex = 2 * f_lvl(tri_lvl(p % 30));
      for (int c = 0; c < CH; c++)
        chk($sformatf("t5_chase_p%0d_ch%0d", p, c), hi[p][c], (c == (p / 30) % 3) ? ex : 0);
    end
    chk("t5_idx_p0", ridx[0], 0);
    chk("t5_idx_p30", ridx[30], 1);
    chk("t5_idx_p60", ridx[60], 2);
    chk("t5_idx_p90", ridx[90], 0);
    repeat (6) @(negedge sys_clk);
    do_load(2'd2, 15, 7, 5);
    repeat (90) @(negedge sys_clk);

    // 6: reset in the middle of a breathing period at level 9
    do_load(2'd1, 15, 7, 5);
    wait_tick("t6");
    measure(9);
    chk("t6_lvl8", hi[8][0], 2 * f_lvl(8));
    repeat (10) @(negedge sys_clk);
    chk("t6_pre_rst_high", int'(pwm_out), 3'b111);
    sys_rst = 1'b1;
    @(negedge sys_clk);
    chk("t6_rst_pwm", int'(pwm_out), 0);
    chk("t6_rst_tick", int'(period_tick), 0);
    chk("t6_rst_idx", int'(chase_idx), 0);
    sys_rst = 1'b0;
    wait_tick("t6_post");
    measure(1);
    chk("t6_post_ch0", hi[0][0], 0);
    chk("t6_post_ch1", hi[0][1], 0);
    chk("t6_post_ch2", hi[0][2], 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
